// File: rtl/tlp_stream_pkg.sv
// -----------------------------------------------------------------------------
// tlp_stream_pkg
// Shared constants and types for the TLP stream packer:
//   - default group size / buffer sizing
//   - header beat layout (length field, reserved byte, 40-bit upstream header)
//   - read-side FSM state encoding
// -----------------------------------------------------------------------------
package tlp_stream_pkg;

  localparam int DEF_DATA_WORDS = 15;
  localparam int DEF_DEPTH_LOG2 = 6;
  localparam int DEF_HDR_DEPTH  = 4;

  localparam logic [15:0] HDR_LEN_FIELD = 16'd15;
  localparam logic [7:0]  HDR_RSVD      = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } rd_state_t;

  // Header beat as seen by the PCIe transmit path.
  function automatic logic [63:0] make_hdr_beat(input logic [39:0] hdr);
    return {HDR_LEN_FIELD, HDR_RSVD, hdr};
  endfunction

endpackage

// File: rtl/tlp_commit_fifo.sv
// -----------------------------------------------------------------------------
// tlp_commit_fifo
// 64-bit data buffer with a speculative write pointer and a commit pointer.
// Words of a group in flight sit between commit and write pointer; a rewind
// throws them away, a commit makes them visible to the reader.
// Ports:
//   InputClock, rst      clock, synchronous active-high reset
//   i_wr_en, i_wr_data   store word at write pointer (ignored when full)
//   i_commit             commit everything written, including this cycle's word
//   i_rewind             discard uncommitted words (wins over commit)
//   i_rd_adv             advance read pointer (caller reads committed data only)
//   o_rd_data            registered word at the (post-advance) read pointer
//   o_free               free slots relative to the read pointer
// -----------------------------------------------------------------------------
module tlp_commit_fifo #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  InputClock,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [63:0]           i_wr_data,
  input  logic                  i_commit,
  input  logic                  i_rewind,
  input  logic                  i_rd_adv,
  output logic [63:0]           o_rd_data,
  output logic [DEPTH_LOG2:0]   o_free
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [63:0]   r_mem [DEPTH];
  logic [63:0]   r_rd_data;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_commit_ptr;
  logic [PW-1:0] r_rd_ptr;

  logic [PW-1:0] w_used;
  logic [PW-1:0] w_rd_ptr_next;
  logic          w_wr_ok;

  // The extra pointer bit makes "used == DEPTH" distinguishable from empty.
  assign w_used        = r_wr_ptr - r_rd_ptr;
  assign o_free        = PW'(DEPTH) - w_used;
  assign w_wr_ok       = i_wr_en & ~w_used[PW-1];
  assign w_rd_ptr_next = r_rd_ptr + PW'(i_rd_adv);
  assign o_rd_data     = r_rd_data;

  always_ff @(posedge InputClock) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_wr_data;
    end
  end

  // Prefetch at the next read address so the word is ready the cycle the
  // pointer lands on it. The reader never sits on an address that is being
  // written, so read-during-write ordering does not matter.
  always_ff @(posedge InputClock) begin
    r_rd_data <= r_mem[w_rd_ptr_next[DEPTH_LOG2-1:0]];
  end

  always_ff @(posedge InputClock) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
    end else begin
      if (i_rewind) begin
        r_wr_ptr <= r_commit_ptr;
      end else if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_commit && !i_rewind) begin
        r_commit_ptr <= r_wr_ptr + PW'(w_wr_ok);
      end
      r_rd_ptr <= w_rd_ptr_next;
    end
  end

endmodule

// File: rtl/tlp_stream_packer.sv
// -----------------------------------------------------------------------------
// tlp_stream_packer
// Buffers 64-bit sample words into complete TLP groups and streams each group
// as a framed packet: one header beat {len, rsvd, hdr} then DATA_WORDS data
// beats. Groups that are short, long, or do not fit are discarded whole.
// Ports:
//   InputClock, rst                 clock, synchronous active-high reset
//   TLPData, DataWriteEnable        upstream sample words (no back-pressure)
//   TLPHeader, HeaderWriteEnable    group header, arrives with the last word
//   m_data, m_valid, m_ready        output beat stream
//   m_sop, m_eop                    header beat / last data beat markers
//   DroppedTLPs                     saturating count of discarded groups
//   ErrorFlag                       sticky group-length error
// -----------------------------------------------------------------------------
module tlp_stream_packer
  import tlp_stream_pkg::*;
#(
  parameter int DATA_WORDS = DEF_DATA_WORDS,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int HDR_DEPTH  = DEF_HDR_DEPTH
) (
  input  logic        InputClock,
  input  logic        rst,
  input  logic [63:0] TLPData,
  input  logic        DataWriteEnable,
  input  logic [39:0] TLPHeader,
  input  logic        HeaderWriteEnable,
  output logic [63:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_sop,
  output logic        m_eop,
  output logic [15:0] DroppedTLPs,
  output logic        ErrorFlag
);

  localparam int CW = $clog2(DATA_WORDS + 1);
  localparam int BW = $clog2(DATA_WORDS);
  localparam int HP = $clog2(HDR_DEPTH);
  localparam logic [CW-1:0] C_LAST = CW'(DATA_WORDS - 1);
  localparam logic [CW-1:0] C_FULL = CW'(DATA_WORDS);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WORDS - 1);
  localparam logic [HP:0]   H_FULL = (HP + 1)'(HDR_DEPTH);

  // ---------------- write side ----------------
  logic [CW-1:0] r_grp_cnt;
  logic          r_drop_grp;
  logic [15:0]   r_dropped;
  logic          r_error;

  logic [DEPTH_LOG2:0] w_free;
  logic [63:0]         w_rd_data;
  logic                w_has_space;
  logic                w_overrun;
  logic                w_len_ok;
  logic                w_wr_en;
  logic                w_grp_valid;
  logic                w_grp_drop;
  logic                w_len_err;
  logic                w_hdr_full;
  logic                w_hdr_empty;
  logic                w_hdr_pop;
  logic                w_rd_adv;

  assign w_has_space = |w_free;
  // r_grp_cnt counts every word of the group, stored or not, so that a group
  // lost to a full buffer is not misreported as a length error.
  assign w_overrun   = DataWriteEnable & (r_grp_cnt == C_FULL);
  assign w_len_ok    = DataWriteEnable & (r_grp_cnt == C_LAST);
  assign w_wr_en     = DataWriteEnable & ~r_drop_grp & ~w_overrun & w_has_space;
  assign w_grp_valid = HeaderWriteEnable & w_len_ok & ~r_drop_grp & w_has_space & ~w_hdr_full;
  assign w_grp_drop  = HeaderWriteEnable & ~w_grp_valid;
  assign w_len_err   = HeaderWriteEnable ? ~w_len_ok : w_overrun;

  assign DroppedTLPs = r_dropped;
  assign ErrorFlag   = r_error;

  always_ff @(posedge InputClock) begin
    if (rst) begin
      r_grp_cnt  <= '0;
      r_drop_grp <= 1'b0;
      r_dropped  <= '0;
      r_error    <= 1'b0;
    end else begin
      if (HeaderWriteEnable) begin
        r_grp_cnt  <= '0;
        r_drop_grp <= 1'b0;
      end else if (DataWriteEnable) begin
        if (r_grp_cnt != C_FULL) begin
          r_grp_cnt <= r_grp_cnt + 1'b1;
        end
        if (w_overrun || !w_has_space) begin
          r_drop_grp <= 1'b1;
        end
      end
      if (w_grp_drop && r_dropped != 16'hFFFF) begin
        r_dropped <= r_dropped + 16'd1;
      end
      if (w_len_err) begin
        r_error <= 1'b1;
      end
    end
  end

  tlp_commit_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .InputClock (InputClock),
    .rst        (rst),
    .i_wr_en    (w_wr_en),
    .i_wr_data  (TLPData),
    .i_commit   (w_grp_valid),
    .i_rewind   (w_grp_drop),
    .i_rd_adv   (w_rd_adv),
    .o_rd_data  (w_rd_data),
    .o_free     (w_free)
  );

  // ---------------- committed-header queue ----------------
  logic [39:0] r_hdr_mem [HDR_DEPTH];
  logic [HP:0] r_hdr_wr;
  logic [HP:0] r_hdr_rd;
  logic [HP:0] w_hdr_used;

  assign w_hdr_used  = r_hdr_wr - r_hdr_rd;
  assign w_hdr_full  = (w_hdr_used == H_FULL);
  assign w_hdr_empty = (w_hdr_used == '0);

  for (genvar gi = 0; gi < HDR_DEPTH; gi++) begin : g_hdr
    always_ff @(posedge InputClock) begin
      if (w_grp_valid && r_hdr_wr[HP-1:0] == HP'(gi)) begin
        r_hdr_mem[gi] <= TLPHeader;
      end
    end
  end

  always_ff @(posedge InputClock) begin
    if (rst) begin
      r_hdr_wr <= '0;
      r_hdr_rd <= '0;
    end else begin
      if (w_grp_valid) r_hdr_wr <= r_hdr_wr + 1'b1;
      if (w_hdr_pop)   r_hdr_rd <= r_hdr_rd + 1'b1;
    end
  end

  // ---------------- read FSM ----------------
  rd_state_t     r_state;
  rd_state_t     w_state_next;
  logic [BW-1:0] r_beat_cnt;
  logic [BW-1:0] w_beat_next;

  always_ff @(posedge InputClock) begin
    if (rst) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_beat_cnt <= w_beat_next;
    end
  end

  // The header stays queued until its beat is accepted, so queue occupancy
  // tracks packets not yet started on the output.
  always_comb begin
    w_state_next = r_state;
    w_beat_next  = r_beat_cnt;
    w_hdr_pop    = 1'b0;
    w_rd_adv     = 1'b0;
    m_valid      = 1'b0;
    m_sop        = 1'b0;
    m_eop        = 1'b0;
    m_data       = '0;
    case (r_state)
      IDLE: begin
        if (!w_hdr_empty) w_state_next = HEADER;
      end
      HEADER: begin
        m_valid = 1'b1;
        m_sop   = 1'b1;
        m_data  = make_hdr_beat(r_hdr_mem[r_hdr_rd[HP-1:0]]);
        if (m_ready) begin
          w_hdr_pop    = 1'b1;
          w_beat_next  = '0;
          w_state_next = DATA;
        end
      end
      DATA: begin
        m_valid = 1'b1;
        m_data  = w_rd_data;
        m_eop   = (r_beat_cnt == B_LAST);
        if (m_ready) begin
          w_rd_adv = 1'b1;
          if (r_beat_cnt == B_LAST) begin
            w_state_next = w_hdr_empty ? IDLE : HEADER;
          end else begin
            w_beat_next = r_beat_cnt + 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: doc/tlp_stream_packer.md
# tlp_stream_packer

Downstream neighbour of the ADC-to-64-bit packer. Collects the 64-bit sample words and the 40-bit per-TLP headers that stage emits, buffers them as complete TLP payload groups, and streams each group as one framed packet (one header beat plus 15 data beats) over a valid/ready interface towards the PCIe transmit path. Incomplete or overflowing groups are discarded as a whole and counted, so the DMA side never sees a partial TLP.

## Interface
- DATA_WORDS, 15, data beats per TLP group; the header strobe arrives with the last word of a group
- DEPTH_LOG2, 6, log2 of data buffer depth in 64-bit words (64 words = 4 groups)
- HDR_DEPTH, 4, committed-header queue depth
- InputClock  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- TLPData  in  64  sample word from upstream
- DataWriteEnable  in  1  TLPData valid this cycle; no back-pressure upstream
- TLPHeader  in  40  {BufferCounter, TLPCounter, ADC sel, half-clk, switcher, 5'b11111}
- HeaderWriteEnable  in  1  group end; coincident with that group's final DataWriteEnable
- m_data  out  64  output beat
- m_valid  out  1  beat valid
- m_ready  in  1  downstream accepts when m_valid & m_ready
- m_sop  out  1  first beat (header) of packet
- m_eop  out  1  last data beat of packet
- DroppedTLPs  out  16  groups discarded since reset; saturates at 16'hFFFF
- ErrorFlag  out  1  sticky; set on any group-length error

## Operation
- Write side: data buffer with two write pointers, wr_ptr (speculative) and commit_ptr; group word counter grp_cnt 0..15.
- Each DataWriteEnable: if buffer has space relative to rd_ptr, store at wr_ptr, wr_ptr++, grp_cnt++; else set drop_grp.
- HeaderWriteEnable (with DataWriteEnable): group valid iff grp_cnt after this word = DATA_WORDS, drop_grp=0, header queue not full. Valid: commit_ptr<=wr_ptr+1, push {16'd15, 8'h00, TLPHeader} to header queue. Invalid: wr_ptr<=commit_ptr (rewind), DroppedTLPs++. Either way grp_cnt<=0, drop_grp<=0.
- Length mismatch (grp_cnt != DATA_WORDS at header, or header without DataWriteEnable, or grp_cnt would exceed DATA_WORDS): group dropped, ErrorFlag<=1. Words beyond 15 without header are discarded and keep drop_grp set until next header.
- Read FSM: IDLE -> HEADER when header queue non-empty; HEADER presents header beat, m_sop=1; on accept -> DATA, beat count 0; DATA presents buffer[rd_ptr], advances rd_ptr on accept; accept of 15th beat (m_eop=1) -> HEADER if another header queued, else IDLE.
- Reads only touch committed region; rewind never affects data already committed.
- Pointer arithmetic modulo 2^DEPTH_LOG2 with one extra wrap bit for full/empty.

## Timing
- Reset values: m_valid=0, m_sop=0, m_eop=0, m_data=0, DroppedTLPs=0, ErrorFlag=0, all pointers/counters 0, FSM IDLE. Reset mid-packet aborts it; no further beats.
- Commit at edge T -> m_valid & m_sop high from edge T+1 when FSM IDLE.
- Back-to-back packets: header beat follows eop with zero idle cycles if queued.
- m_data/m_sop/m_eop held stable while m_valid & ~m_ready; m_valid never drops without acceptance.
- Full throughput 1 beat/cycle; upstream rate 1 word per 5 or 8 clocks, so overflow occurs only under sustained stall.
- Same-cycle commit and last-beat read: both take effect; full/empty computed from registered pointers.

## Structure
- Package tlp_stream_pkg: DATA_WORDS default, header beat layout constants (length field 16'd15, reserved 8'h00), FSM state enum {IDLE, HEADER, DATA}.
- One sub-module tlp_commit_fifo: data RAM with wr/commit/rd pointers, commit and rewind strobes, free-space output. Header queue is a plain small FIFO inside the top.

## Test plan
- 15 words, header on 15th, m_ready=1 -> 16 beats: beat0={16'd15,8'h00,hdr} with m_sop, beats 1..15 = words in order, m_eop on beat 15.
- Header arrives with 14th word -> no packet, DroppedTLPs=1, ErrorFlag=1; next correct group emitted intact.
- m_ready=0 for 80 groups' worth of input -> 4 groups emitted later unchanged, later groups dropped whole, DroppedTLPs counts them; no partial packet.
- Two groups committed, m_ready toggling every cycle -> 32 beats, data stable while stalled, no gap between eop and next sop when ready.
- rst asserted during beat 7 of a packet -> all outputs 0 next cycle; next full group after reset emits correctly.
- DroppedTLPs at 16'hFFFF plus another drop -> stays 16'hFFFF.
